// File: rtl/dnn_seq_pkg.sv
// -----------------------------------------------------------------------------
// dnn_seq_pkg
// Shared definitions for the DNN layer sequencer: FSM state encoding, counter
// and address widths, and helpers for per-layer fan-in / fan-out and for the
// ROM-read plus MAC pipeline latency.
// No ports (package).
// -----------------------------------------------------------------------------
package dnn_seq_pkg;

    // Activation RAM index width (up to 128 neurons per layer).
    localparam int ACT_AW = 7;
    // Layer counter width; comfortably covers any practical layer count.
    localparam int LYR_W  = 4;
    // Drain down-counter width.
    localparam int TMR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_t;

    // Total cycles between the last issue and the result being ready to write.
    function automatic int seq_lat(input int rd_lat, input int mac_lat);
        return rd_lat + mac_lat;
    endfunction

    // Index of the final input term of a neuron in the given layer.
    function automatic logic [ACT_AW-1:0] fan_in_last(input logic [LYR_W-1:0] layer,
                                                      input int n_in,
                                                      input int n_hid);
        if (layer == '0) begin
            return ACT_AW'(n_in - 1);
        end
        return ACT_AW'(n_hid - 1);
    endfunction

    // Index of the final neuron of the given layer.
    function automatic logic [ACT_AW-1:0] fan_out_last(input logic [LYR_W-1:0] layer,
                                                       input logic [LYR_W-1:0] last_layer,
                                                       input int n_out,
                                                       input int n_hid);
        if (layer == last_layer) begin
            return ACT_AW'(n_out - 1);
        end
        return ACT_AW'(n_hid - 1);
    endfunction

endpackage

// File: rtl/dnn_seq_delay.sv
// -----------------------------------------------------------------------------
// dnn_seq_delay
// Fixed-depth shift register that re-times the issue valid/last pair so the
// MAC enable lines up with data returning from the ROM/RAM read pipeline.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset (clears the pipeline)
//   in_valid   in   issue valid
//   in_last    in   issue last (final term of a neuron)
//   out_valid  out  in_valid delayed DEPTH cycles
//   out_last   out  in_last delayed DEPTH cycles
// -----------------------------------------------------------------------------
module dnn_seq_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] v_sr;
    logic [DEPTH-1:0] l_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr[0] <= in_valid;
            l_sr[0] <= in_last;
            for (int i = 1; i < DEPTH; i++) begin
                v_sr[i] <= v_sr[i-1];
                l_sr[i] <= l_sr[i-1];
            end
        end
    end

    assign out_valid = v_sr[DEPTH-1];
    assign out_last  = l_sr[DEPTH-1];

endmodule

// File: rtl/dnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// dnn_layer_sequencer
// Time-multiplexes one MAC datapath across every layer of the word-detect DNN.
// On a feature-frame strobe it walks layer -> neuron -> input, producing
// weight-ROM and activation-RAM addresses, MAC clear/enable/last, and the
// activation writeback, ping-ponging between two activation banks (layer L
// reads bank L mod 2 and writes the other one).
//
// Optional feature: define DNN_SEQ_OVERRUN_CNT_EN to add drop_cnt, a
// saturating count of frame_drop pulses.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   dv_in        in   1-cycle strobe: feature frame ready in bank 0
//   w_addr       out  weight-ROM address, contiguous across all layers
//   act_rd_addr  out  activation read index (0 outside issue)
//   act_rd_bank  out  bank read by the current layer
//   mac_clr      out  clear accumulator
//   mac_en       out  accumulate, issue valid delayed RD_LAT
//   mac_last     out  final term of a neuron, aligned with mac_en
//   act_wr_en    out  write activation result
//   act_wr_addr  out  neuron index written
//   act_wr_bank  out  bank written (complement of act_rd_bank)
//   act_relu     out  1 = hidden layer, 0 = output layer
//   busy         out  inference in progress
//   done         out  1-cycle pulse after the last output-layer write
//   frame_drop   out  1-cycle pulse, the cycle after dv_in arrived while busy
//   drop_cnt     out  saturating frame_drop count (DNN_SEQ_OVERRUN_CNT_EN only)
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for dv_in
// CLEAR | clear accumulator for the next neuron, reset input index
// ISSUE | one input term per cycle: ROM/RAM address + issue valid
// DRAIN | wait LAT cycles for the last term to leave the MAC pipeline
// WRITE | write the neuron result to the other bank
// NEXT  | advance to the next layer
// DONE  | frame complete; dv_in here starts the next frame directly
// -----------------------------------------------------------------------------
module dnn_layer_sequencer
    import dnn_seq_pkg::*;
#(
    parameter int N_IN     = 20,
    parameter int N_HID    = 64,
    parameter int N_OUT    = 11,
    parameter int N_LAYERS = 3,   // must be >= 2
    parameter int RD_LAT   = 1,
    parameter int MAC_LAT  = 1,
    parameter int WA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dv_in,
    output logic [WA_W-1:0]   w_addr,
    output logic [ACT_AW-1:0] act_rd_addr,
    output logic              act_rd_bank,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              mac_last,
    output logic              act_wr_en,
    output logic [ACT_AW-1:0] act_wr_addr,
    output logic              act_wr_bank,
    output logic              act_relu,
    output logic              busy,
    output logic              done,
    output logic              frame_drop
`ifdef DNN_SEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam logic [LYR_W-1:0] LAST_LAYER = LYR_W'(N_LAYERS - 1);
    // DRAIN lasts LAT cycles: counter loads LAT-1 and exits on terminal count 0.
    localparam logic [TMR_W-1:0] DRAIN_INIT = TMR_W'(seq_lat(RD_LAT, MAC_LAT) - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [LYR_W-1:0]  layer;
    logic [ACT_AW-1:0] neuron;
    logic [ACT_AW-1:0] idx;
    logic [TMR_W-1:0]  tmr;
    logic [WA_W-1:0]   w_addr_q;
    logic [ACT_AW-1:0] fin_last;
    logic [ACT_AW-1:0] fout_last;
    logic              is_last_layer;
    logic              issue_v;
    logic              issue_last;

    assign fin_last      = fan_in_last(layer, N_IN, N_HID);
    assign fout_last     = fan_out_last(layer, LAST_LAYER, N_OUT, N_HID);
    assign is_last_layer = (layer == LAST_LAYER);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (dv_in) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_ISSUE;
            ST_ISSUE: if (idx == fin_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (tmr == '0) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (neuron == fout_last) ? ST_NEXT : ST_CLEAR;
            ST_NEXT:  state_nxt = is_last_layer ? ST_DONE : ST_CLEAR;
            ST_DONE:  state_nxt = dv_in ? ST_CLEAR : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mac_clr   = 1'b0;
        issue_v   = 1'b0;
        act_wr_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE:  busy      = 1'b0;
            ST_CLEAR: mac_clr   = 1'b1;
            ST_ISSUE: issue_v   = 1'b1;
            ST_WRITE: act_wr_en = 1'b1;
            ST_DONE:  done      = 1'b1;
            default:  ;
        endcase
    end

    assign issue_last  = issue_v && (idx == fin_last);
    assign act_rd_addr = issue_v ? idx : '0;
    // Bank/relu are gated by busy so IDLE (and reset) present all-zero outputs.
    assign act_rd_bank = busy & layer[0];
    assign act_wr_bank = busy & ~layer[0];
    assign act_relu    = busy & ~is_last_layer;
    assign act_wr_addr = neuron;
    assign w_addr      = w_addr_q;

    // Walk counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer    <= '0;
            neuron   <= '0;
            idx      <= '0;
            tmr      <= '0;
            w_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (dv_in) begin
                        layer    <= '0;
                        neuron   <= '0;
                        w_addr_q <= '0;
                    end
                end
                ST_CLEAR: idx <= '0;
                ST_ISSUE: begin
                    // Weights are stored neuron-major, so the ROM address
                    // is a plain running counter across neurons and layers.
                    w_addr_q <= w_addr_q + WA_W'(1);
                    if (idx == fin_last) begin
                        tmr <= DRAIN_INIT;
                    end else begin
                        idx <= idx + ACT_AW'(1);
                    end
                end
                ST_DRAIN: if (tmr != '0) tmr <= tmr - TMR_W'(1);
                ST_WRITE: if (neuron != fout_last) neuron <= neuron + ACT_AW'(1);
                ST_NEXT: begin
                    neuron <= '0;
                    // Layer stays on the output layer through DONE so act_relu
                    // and the bank selects stay consistent until restart.
                    if (!is_last_layer) layer <= layer + LYR_W'(1);
                end
                default: ;
            endcase
        end
    end

    dnn_seq_delay #(
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_v),
        .in_last   (issue_last),
        .out_valid (mac_en),
        .out_last  (mac_last)
    );

    // A strobe in DONE is a legal back-to-back frame, not an overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= dv_in && (state != ST_IDLE) && (state != ST_DONE);
        end
    end

`ifdef DNN_SEQ_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (frame_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dnn_layer_sequencer
// Scoreboard bench. The stimulus side decides, from the frame timing rules,
// whether each dv_in strobe is accepted or dropped, and pushes the expected
// MAC terms, writebacks, done cycle and frame_drop cycle into queues. Monitors
// on the falling edge pop and compare whenever the DUT presents an event.
// A second instance with the default network and RD_LAT=2 checks the enable
// lag and per-neuron mac_last on a full-size run.
// -----------------------------------------------------------------------------
module tb_dnn_layer_sequencer;

    localparam int P_IN = 4, P_HID = 3, P_OUT = 2, P_LAY = 2, P_RD = 1, P_MAC = 1;
    localparam int D_IN = 20, D_HID = 64, D_OUT = 11, D_LAY = 3, D_RD = 2, D_MAC = 1;

    typedef struct {
        logic [15:0] wa;
        logic [6:0]  ra;
        logic        bank;
        logic        last;
    } term_t;

    typedef struct {
        logic [6:0] addr;
        logic       bank;
        logic       relu;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dv_in = 1'b0;
    logic dv2   = 1'b0;

    logic [15:0] w_addr, w_addr2;
    logic [6:0]  act_rd_addr, act_rd_addr2, act_wr_addr, act_wr_addr2;
    logic        act_rd_bank, mac_clr, mac_en, mac_last, act_wr_en, act_wr_bank;
    logic        act_relu, busy, done, frame_drop;
    logic        act_rd_bank2, mac_clr2, mac_en2, mac_last2, act_wr_en2, act_wr_bank2;
    logic        act_relu2, busy2, done2, frame_drop2;
`ifdef DNN_SEQ_OVERRUN_CNT_EN
    logic [15:0] drop_cnt, drop_cnt2;
`endif

    logic [39:0] out1_vec, out2_vec;
    assign out1_vec = {w_addr, act_rd_addr, act_rd_bank, mac_clr, mac_en, mac_last,
                       act_wr_en, act_wr_addr, act_wr_bank, act_relu, busy, done, frame_drop};
    assign out2_vec = {w_addr2, act_rd_addr2, act_rd_bank2, mac_clr2, mac_en2, mac_last2,
                       act_wr_en2, act_wr_addr2, act_wr_bank2, act_relu2, busy2, done2, frame_drop2};

    dnn_layer_sequencer #(
        .N_IN(P_IN), .N_HID(P_HID), .N_OUT(P_OUT), .N_LAYERS(P_LAY),
        .RD_LAT(P_RD), .MAC_LAT(P_MAC), .WA_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dv_in       (dv_in),
        .w_addr      (w_addr),
        .act_rd_addr (act_rd_addr),
        .act_rd_bank (act_rd_bank),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_last    (mac_last),
        .act_wr_en   (act_wr_en),
        .act_wr_addr (act_wr_addr),
        .act_wr_bank (act_wr_bank),
        .act_relu    (act_relu),
        .busy        (busy),
        .done        (done),
        .frame_drop  (frame_drop)
`ifdef DNN_SEQ_OVERRUN_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    dnn_layer_sequencer #(
        .N_IN(D_IN), .N_HID(D_HID), .N_OUT(D_OUT), .N_LAYERS(D_LAY),
        .RD_LAT(D_RD), .MAC_LAT(D_MAC), .WA_W(16)
    ) dut_dflt (
        .clk         (clk),
        .reset       (reset),
        .dv_in       (dv2),
        .w_addr      (w_addr2),
        .act_rd_addr (act_rd_addr2),
        .act_rd_bank (act_rd_bank2),
        .mac_clr     (mac_clr2),
        .mac_en      (mac_en2),
        .mac_last    (mac_last2),
        .act_wr_en   (act_wr_en2),
        .act_wr_addr (act_wr_addr2),
        .act_wr_bank (act_wr_bank2),
        .act_relu    (act_relu2),
        .busy        (busy2),
        .done        (done2),
        .frame_drop  (frame_drop2)
`ifdef DNN_SEQ_OVERRUN_CNT_EN
        ,
        .drop_cnt    (drop_cnt2)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    term_t term_q[$];
    wr_t   wr_q[$];
    int    done_q[$];
    int    drop_q[$];

    int act_a  = -1;   // accept edge of the most recent frame, -1 = none
    int n_drop = 0;
    int L1, L2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int fin_of(input int l, input int n_in, input int n_hid);
        return (l == 0) ? n_in : n_hid;
    endfunction

    function automatic int fout_of(input int l, input int nl, input int n_out, input int n_hid);
        return (l == nl - 1) ? n_out : n_hid;
    endfunction

    function automatic int frame_len(input int n_in, input int n_hid, input int n_out,
                                     input int nl, input int lat);
        int s = 0;
        for (int l = 0; l < nl; l++)
            s += fout_of(l, nl, n_out, n_hid) * (fin_of(l, n_in, n_hid) + lat + 2) + 1;
        return s;
    endfunction

    // Expected activity of one accepted frame in the small network.
    task automatic push_frame(input int a);
        int wa = 0;
        for (int l = 0; l < P_LAY; l++) begin
            for (int n = 0; n < fout_of(l, P_LAY, P_OUT, P_HID); n++) begin
                for (int i = 0; i < fin_of(l, P_IN, P_HID); i++) begin
                    term_q.push_back('{16'(wa), 7'(i), 1'(l % 2),
                                       (i == fin_of(l, P_IN, P_HID) - 1)});
                    wa++;
                end
                wr_q.push_back('{7'(n), 1'((l + 1) % 2), (l != P_LAY - 1)});
            end
        end
        done_q.push_back(a + L1);
    endtask

    // Called #1 after a rising edge; the strobe is sampled on the next edge e.
    // The DUT is busy (not DONE) on edges a+1 .. a+L1 of a frame accepted at a.
    task automatic drive_dv();
        int e;
        dv_in = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        dv_in = 1'b0;
        if (act_a >= 0 && e >= act_a + 1 && e <= act_a + L1) begin
            drop_q.push_back(e);
            n_drop++;
        end else begin
            act_a = e;
            push_frame(e);
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((done_q.size() != 0 || term_q.size() != 0 || wr_q.size() != 0) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pending_done", done_q.size(), 0);
        chk("pending_terms", term_q.size(), 0);
        chk("pending_writes", wr_q.size(), 0);
    endtask

    // Monitor for the small instance.
    initial begin : mon1
        logic [15:0] wa_h[4];
        logic [6:0]  ra_h[4];
        logic        rb_h[4];
        term_t t;
        wr_t   w;
        int    d;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mac_en) begin
                    if (term_q.size() == 0) begin
                        chk("mac_en_spurious", term_q.size(), 1);
                    end else begin
                        t = term_q.pop_front();
                        chk("w_addr", wa_h[P_RD-1], t.wa);
                        chk("act_rd_addr", ra_h[P_RD-1], t.ra);
                        chk("act_rd_bank", rb_h[P_RD-1], t.bank);
                        chk("mac_last", mac_last, t.last);
                    end
                end else if (mac_last) begin
                    chk("mac_last_alone", mac_en, 1);
                end
                if (act_wr_en) begin
                    if (wr_q.size() == 0) begin
                        chk("wr_spurious", wr_q.size(), 1);
                    end else begin
                        w = wr_q.pop_front();
                        chk("act_wr_addr", act_wr_addr, w.addr);
                        chk("act_wr_bank", act_wr_bank, w.bank);
                        chk("act_relu", act_relu, w.relu);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("done_spurious", done_q.size(), 1);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d);
                        chk("busy_at_done", busy, 1);
                    end
                end
                if (frame_drop) begin
                    if (drop_q.size() == 0) begin
                        chk("frame_drop_spurious", drop_q.size(), 1);
                    end else begin
                        d = drop_q.pop_front();
                        chk("frame_drop_cycle", cyc, d);
                    end
                end
            end
            for (int k = 3; k > 0; k--) begin
                wa_h[k] = wa_h[k-1];
                ra_h[k] = ra_h[k-1];
                rb_h[k] = rb_h[k-1];
            end
            wa_h[0] = w_addr;
            ra_h[0] = act_rd_addr;
            rb_h[0] = act_rd_bank;
        end
    end

    // Monitor for the default-size instance: every mac_en must match the
    // weight address issued exactly two cycles earlier.
    int k2 = 0;
    int done2_cyc = -1;
    initial begin : mon2
        logic [15:0] wa2_h[2];
        int m_l, m_n, m_i, fi;
        m_l = 0; m_n = 0; m_i = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mac_en2) begin
                    fi = fin_of(m_l, D_IN, D_HID);
                    chk("dflt_w_addr_lag", wa2_h[D_RD-1], k2);
                    chk("dflt_mac_last", mac_last2, (m_i == fi - 1) ? 1 : 0);
                    k2++;
                    m_i++;
                    if (m_i == fi) begin
                        m_i = 0;
                        m_n++;
                        if (m_n == fout_of(m_l, D_LAY, D_OUT, D_HID)) begin
                            m_n = 0;
                            m_l++;
                        end
                    end
                end else if (mac_last2) begin
                    chk("dflt_mac_last_alone", mac_en2, 1);
                end
                if (done2) done2_cyc = cyc;
            end
            wa2_h[1] = wa2_h[0];
            wa2_h[0] = w_addr2;
        end
    end

    initial begin : stim
        int a0, a2, t, terms2;
        L1 = frame_len(P_IN, P_HID, P_OUT, P_LAY, P_RD + P_MAC);
        L2 = frame_len(D_IN, D_HID, D_OUT, D_LAY, D_RD + D_MAC);
        terms2 = 0;
        for (int l = 0; l < D_LAY; l++)
            terms2 += fout_of(l, D_LAY, D_OUT, D_HID) * fin_of(l, D_IN, D_HID);

        #2 reset = 1'b0;
        #2;
        chk("reset_outputs", out1_vec, 0);
        chk("reset_outputs_dflt", out2_vec, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // single frame
        drive_dv();
        wait_idle(100);

        // overrun strobe 10 cycles into a frame
        drive_dv();
        a0 = act_a;
        wait_edge(a0 + 9);
        drive_dv();
        wait_idle(100);
        chk("no_restart_busy", busy, 0);
`ifdef DNN_SEQ_OVERRUN_CNT_EN
        chk("drop_cnt_one", drop_cnt, n_drop);
`endif

        // back-to-back: strobe during the DONE cycle
        drive_dv();
        a0 = act_a;
        wait_edge(a0 + L1);
        drive_dv();
        wait_idle(200);

        // random strobe spacing
        repeat (12) begin
            wait_edge(cyc + int'($urandom_range(0, 45)));
            drive_dv();
        end
        wait_idle(600);
`ifdef DNN_SEQ_OVERRUN_CNT_EN
        chk("drop_cnt_random", drop_cnt, n_drop);
`endif

        // reset in the middle of layer 1 issue
        drive_dv();
        a0 = act_a;
        wait_edge(a0 + 27);
        chk("l1_issue_rd_bank", act_rd_bank, 1);
        chk("l1_issue_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", out1_vec, 0);
        term_q.delete();
        wr_q.delete();
        done_q.delete();
        drop_q.delete();
        act_a = -1;
        n_drop = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        drive_dv();
        wait_idle(100);
`ifdef DNN_SEQ_OVERRUN_CNT_EN
        chk("drop_cnt_after_reset", drop_cnt, n_drop);
`endif

        // default network, RD_LAT = 2
        dv2 = 1'b1;
        @(posedge clk);
        #1;
        a2 = cyc;
        dv2 = 1'b0;
        t = 0;
        while (done2_cyc < 0 && t < L2 + 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("dflt_done_latency", done2_cyc - a2, L2);
        chk("dflt_term_count", k2, terms2);
        chk("final_drop_queue", drop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
